// File: rtl/uart_pkg.sv
// uart_pkg: parity modes, receiver FSM states and the majority-vote helper shared by the UART blocks
package uart_pkg;
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_e;
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: oversample tick generator; clr restarts the divider so ticks line up with a frame edge
module uart_baud_tick #(
    parameter int SYS_CLK    = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int TICK_DIV = SYS_CLK / (BAUD * OVERSAMPLE);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    logic [CW-1:0] cnt_q;
    logic wrap;
    assign wrap = cnt_q == CW'(TICK_DIV - 1);
    assign tick = wrap & ~clr;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt_q <= '0;
        else cnt_q <= (clr || wrap) ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x-oversampled UART receiver with majority voting, error flags and a one-frame
// valid/ready holding register
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int SYS_CLK    = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_data,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_parity_err,
    output logic                 out_frame_err,
    output logic                 out_overrun,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int HALF = OVERSAMPLE / 2;
    localparam int SW = $clog2(OVERSAMPLE);
    state_e state_q;
    logic [2:0] sync_q;
    logic rxs_prev_q;
    logic [SW-1:0] s_q;
    logic [1:0] smp_q;
    logic [2:0] bit_q;
    logic [DATA_BITS-1:0] sh_q;
    logic perr_q, ferr_q, commit_q;
    logic [DATA_BITS-1:0] data_q;
    logic hperr_q, hferr_q, ovr_q, valid_q;
    logic rxs, fall, clr, tick, decide, eob, vote, ferr_d;
    assign rxs = sync_q[2];
    assign fall = rxs_prev_q & ~rxs;
    assign clr = fall && state_q == S_IDLE;
    assign decide = tick && s_q == SW'(HALF + 1);
    assign eob = tick && s_q == SW'(OVERSAMPLE - 1);
    assign vote = maj3(smp_q[1], smp_q[0], rxs);
    assign ferr_d = (bit_q == 3'd0 ? 1'b0 : ferr_q) | ~vote;
    uart_baud_tick #(.SYS_CLK(SYS_CLK), .BAUD(BAUD), .OVERSAMPLE(OVERSAMPLE)) u_tick (
        .clk(clk), .rst_n(rst_n), .clr(clr), .tick(tick)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q    <= S_IDLE;
            sync_q     <= 3'b111;
            rxs_prev_q <= 1'b1;
            s_q        <= '0;
            smp_q      <= 2'b11;
            bit_q      <= '0;
            sh_q       <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            commit_q   <= 1'b0;
        end else begin
            sync_q     <= {sync_q[1:0], in_data};
            rxs_prev_q <= rxs;
            commit_q   <= 1'b0;
            if (tick) s_q <= eob ? '0 : s_q + 1'b1;
            if (tick && s_q == SW'(HALF - 1)) smp_q[1] <= rxs;
            if (tick && s_q == SW'(HALF)) smp_q[0] <= rxs;
            case (state_q)
                S_IDLE: if (fall) begin
                    state_q <= S_START;
                    s_q     <= '0;
                end
                S_START: if (decide && vote) state_q <= S_IDLE;
                else if (eob) begin
                    state_q <= S_DATA;
                    bit_q   <= '0;
                end
                S_DATA: begin
                    if (decide) sh_q <= {vote, sh_q[DATA_BITS-1:1]};
                    if (eob) begin
                        bit_q <= bit_q + 1'b1;
                        if (bit_q == 3'(DATA_BITS - 1)) begin
                            state_q <= (PARITY == PARITY_NONE) ? S_STOP : S_PARITY;
                            bit_q   <= '0;
                        end
                    end
                end
                S_PARITY: begin
                    if (decide) perr_q <= (^sh_q ^ vote) != (PARITY == PARITY_ODD);
                    if (eob) begin
                        state_q <= S_STOP;
                        bit_q   <= '0;
                    end
                end
                // complete at the last stop decision point so a back-to-back start edge is not missed
                S_STOP: if (decide) begin
                    ferr_q <= ferr_d;
                    if (bit_q == 3'(STOP_BITS - 1)) begin
                        commit_q <= 1'b1;
                        state_q  <= ferr_d ? S_BREAK : S_IDLE;
                    end
                end else if (eob) bit_q <= bit_q + 1'b1;
                S_BREAK: if (rxs) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            data_q  <= '0;
            hperr_q <= 1'b0;
            hferr_q <= 1'b0;
            ovr_q   <= 1'b0;
            valid_q <= 1'b0;
        end else if (commit_q) begin
            if (!valid_q || out_ready) begin
                data_q  <= sh_q;
                hperr_q <= perr_q;
                hferr_q <= ferr_q;
                ovr_q   <= 1'b0;
                valid_q <= 1'b1;
            end else ovr_q <= 1'b1;
        end else if (valid_q && out_ready) begin
            data_q  <= '0;
            hperr_q <= 1'b0;
            hferr_q <= 1'b0;
            ovr_q   <= 1'b0;
            valid_q <= 1'b0;
        end
    assign out_data = data_q;
    assign out_parity_err = hperr_q;
    assign out_frame_err = hferr_q;
    assign out_overrun = ovr_q;
    assign out_valid = valid_q;
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: scoreboard bench for three receiver configurations (8N1, 8E1, 7O2)
`timescale 1ns/1ps
module tb_uart_rx_os;
    localparam int SYS = 50_000_000;
    localparam int BAUD = 781_250;   // divider of 4 keeps each bit at 64 clocks
    localparam int BIT = SYS / BAUD;
    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;
    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] line = 3'b111;
    logic [2:0] rdy = 3'b111;
    logic [2:0] vl, pe, fe, ov;
    logic [2:0] hs_q = 3'b000;
    logic [7:0] od0, od1;
    logic [6:0] od2;
    logic [7:0] od [3];
    always #10 clk = ~clk;
    always_comb begin
        od[0] = od0;
        od[1] = od1;
        od[2] = {1'b0, od2};
    end
    uart_rx_os #(.SYS_CLK(SYS), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_8n1 (
        .clk(clk), .rst_n(rst_n), .in_data(line[0]), .out_data(od0), .out_parity_err(pe[0]),
        .out_frame_err(fe[0]), .out_overrun(ov[0]), .out_valid(vl[0]), .out_ready(rdy[0])
    );
    uart_rx_os #(.SYS_CLK(SYS), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_8e1 (
        .clk(clk), .rst_n(rst_n), .in_data(line[1]), .out_data(od1), .out_parity_err(pe[1]),
        .out_frame_err(fe[1]), .out_overrun(ov[1]), .out_valid(vl[1]), .out_ready(rdy[1])
    );
    uart_rx_os #(.SYS_CLK(SYS), .BAUD(BAUD), .OVERSAMPLE(16), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_7o2 (
        .clk(clk), .rst_n(rst_n), .in_data(line[2]), .out_data(od2), .out_parity_err(pe[2]),
        .out_frame_err(fe[2]), .out_overrun(ov[2]), .out_valid(vl[2]), .out_ready(rdy[2])
    );
    // monitor: pops on each handshake; the cycle after a handshake the outputs must read all zero
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (hs_q[i]) begin
                n_cmp++;
                if (vl[i] || od[i] != 8'h00 || pe[i] || fe[i] || ov[i]) begin
                    n_bad++;
                    $display("FAIL clear%0d: got valid=%b data=%h p=%b f=%b o=%b, want all 0",
                             i, vl[i], od[i], pe[i], fe[i], ov[i]);
                end
            end
            if (rst_n && vl[i] && rdy[i]) begin
                n_cmp++;
                if (q.size() == 0 || q[0].id != 2'(i)) begin
                    n_bad++;
                    $display("FAIL frame%0d: got unexpected data=%h p=%b f=%b o=%b, want no frame",
                             i, od[i], pe[i], fe[i], ov[i]);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if ({od[i], pe[i], fe[i], ov[i]} != {e.data, e.perr, e.ferr, e.ovr}) begin
                        n_bad++;
                        $display("FAIL frame%0d: got data=%h p=%b f=%b o=%b, want data=%h p=%b f=%b o=%b",
                                 i, od[i], pe[i], fe[i], ov[i], e.data, e.perr, e.ferr, e.ovr);
                    end
                end
            end
            hs_q[i] <= rst_n && vl[i] && rdy[i];
        end
    end
    task automatic drive(input int id, input logic v, input int n);
        line[id] = v;
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic send_frame(input int id, input logic [7:0] d, input int db, input int pm,
                              input logic pb, input int sb);
        drive(id, 1'b0, BIT);
        for (int i = 0; i < db; i++) drive(id, d[i], BIT);
        if (pm != 0) drive(id, pb, BIT);
        for (int i = 0; i < sb; i++) drive(id, 1'b1, BIT);
    endtask
    task automatic push(input int id, input logic [7:0] d, input logic p, input logic f, input logic o);
        exp_t e;
        e.id = 2'(id);
        e.data = d;
        e.perr = p;
        e.ferr = f;
        e.ovr = o;
        q.push_back(e);
    endtask
    task automatic drain(input string tag);
        int t = 0;
        while (q.size() != 0 && t < 4000) begin
            @(posedge clk);
            #1;
            t++;
        end
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL %s: got %0d frames outstanding, want 0", tag, q.size());
            q.delete();
        end
    endtask
    task automatic check_reset(input string tag);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (vl[i] || od[i] != 8'h00 || pe[i] || fe[i] || ov[i]) begin
                n_bad++;
                $display("FAIL %s%0d: got valid=%b data=%h p=%b f=%b o=%b, want all 0",
                         tag, i, vl[i], od[i], pe[i], fe[i], ov[i]);
            end
        end
    endtask
    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset("reset");
        rst_n = 1'b1;
        drive(0, 1'b1, BIT);
        push(0, 8'h55, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h55, 8, 0, 1'b0, 1);
        push(0, 8'h00, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h00, 8, 0, 1'b0, 1);
        push(0, 8'hFF, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'hFF, 8, 0, 1'b0, 1);
        drive(0, 1'b1, BIT);
        drain("8n1");
        push(1, 8'hA3, 1'b1, 1'b0, 1'b0);
        send_frame(1, 8'hA3, 8, 1, 1'b1, 1);
        push(1, 8'hA3, 1'b0, 1'b0, 1'b0);
        send_frame(1, 8'hA3, 8, 1, 1'b0, 1);
        drive(1, 1'b1, BIT);
        drain("8e1");
        push(0, 8'h00, 1'b0, 1'b1, 1'b0);
        drive(0, 1'b0, 12 * BIT);
        drive(0, 1'b1, 3 * BIT);
        drain("break");
        drive(0, 1'b0, 16);
        drive(0, 1'b1, 2 * BIT);
        push(0, 8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(0, 8'h3C, 8, 0, 1'b0, 1);
        drive(0, 1'b1, BIT);
        drain("glitch");
        rdy[0] = 1'b0;
        send_frame(0, 8'h11, 8, 0, 1'b0, 1);
        send_frame(0, 8'h22, 8, 0, 1'b0, 1);
        drive(0, 1'b1, BIT);
        n_cmp++;
        if (!vl[0] || od[0] != 8'h11 || !ov[0] || pe[0] || fe[0]) begin
            n_bad++;
            $display("FAIL held: got valid=%b data=%h o=%b, want valid=1 data=11 o=1", vl[0], od[0], ov[0]);
        end
        drive(0, 1'b1, 2 * BIT);
        n_cmp++;
        if (!vl[0] || od[0] != 8'h11 || !ov[0]) begin
            n_bad++;
            $display("FAIL stable: got valid=%b data=%h o=%b, want valid=1 data=11 o=1", vl[0], od[0], ov[0]);
        end
        push(0, 8'h11, 1'b0, 1'b0, 1'b1);
        rdy[0] = 1'b1;
        drain("overrun");
        n_cmp++;
        if (vl[0] || ov[0]) begin
            n_bad++;
            $display("FAIL accept: got valid=%b o=%b, want valid=0 o=0", vl[0], ov[0]);
        end
        drive(2, 1'b0, BIT);
        drive(2, 1'b0, BIT);
        drive(2, 1'b1, BIT);
        drive(2, 1'b0, BIT / 2);
        rst_n = 1'b0;
        line[2] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check_reset("midrst");
        rst_n = 1'b1;
        drive(2, 1'b1, 2 * BIT);
        push(2, 8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(2, 8'h5A, 7, 1, 1'b1, 2);
        drive(2, 1'b1, BIT);
        drain("7o2");
        drive(0, 1'b1, 2 * BIT);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
